// File: rtl/cache_arbiter.sv
// Arbitrates the shared 256-bit memory port between the I-cache miss path and the
// D-cache miss/writeback path; one requester at a time, round-robin on ties.
module cache_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst,
  // instruction cache
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  // data cache
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  // physical memory
  output logic              read,
  output logic              write,
  output logic [ADDR_W-1:0] address,
  output logic [LINE_W-1:0] wdata,
  input  logic              resp,
  input  logic [LINE_W-1:0] rdata
);

  typedef enum logic [1:0] {StIdle, StServeI, StServeD} state_e;

  state_e            state_q, state_d;
  logic              last_d_q, last_d_d;  // high when the most recent tie went to D
  logic              read_q, read_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] address_q, address_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;

  logic i_req, d_req, grant_i;

  assign i_req = i_read;
  assign d_req = d_read | d_write;

  always_comb begin
    state_d   = state_q;
    last_d_d  = last_d_q;
    read_d    = read_q;
    write_d   = write_q;
    address_d = address_q;
    wdata_d   = wdata_q;
    grant_i   = 1'b0;
    case (state_q)
      StIdle: begin
        grant_i = i_req & (~d_req | last_d_q);
        // Only a genuine tie moves the round-robin pointer.
        if (i_req && d_req) last_d_d = ~grant_i;
        if (grant_i) begin
          state_d   = StServeI;
          read_d    = 1'b1;
          write_d   = 1'b0;
          address_d = i_address;
        end else if (d_req) begin
          state_d   = StServeD;
          read_d    = d_read & ~d_write;  // write wins a conflicting request
          write_d   = d_write;
          address_d = d_address;
          wdata_d   = d_wdata;
        end
      end
      StServeI, StServeD: begin
        if (resp) begin
          state_d = StIdle;
          read_d  = 1'b0;
          write_d = 1'b0;
        end
      end
      default: begin
        state_d = StIdle;
        read_d  = 1'b0;
        write_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      last_d_q  <= 1'b1;
      read_q    <= 1'b0;
      write_q   <= 1'b0;
      address_q <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      last_d_q  <= last_d_d;
      read_q    <= read_d;
      write_q   <= write_d;
      address_q <= address_d;
      wdata_q   <= wdata_d;
    end
  end

  assign read    = read_q;
  assign write   = write_q;
  assign address = address_q;
  assign wdata   = wdata_q;

  assign i_resp  = (state_q == StServeI) & resp;
  assign d_resp  = (state_q == StServeD) & resp;
  assign i_rdata = rdata;
  assign d_rdata = rdata;

endmodule

// File: tb/tb_cache_arbiter.sv
// Self-checking bench for cache_arbiter: directed scenarios plus a randomized run
// against a transaction-level model of the arbitration rules.
module tb_cache_arbiter;

  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_read;
  logic [ADDR_W-1:0] i_address;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;
  logic              d_read, d_write;
  logic [ADDR_W-1:0] d_address;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;
  logic              read, write;
  logic [ADDR_W-1:0] address;
  logic [LINE_W-1:0] wdata;
  logic              resp;
  logic [LINE_W-1:0] rdata;

  int n_cmp  = 0;
  int n_fail = 0;

  cache_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_read    (i_read),
    .i_address (i_address),
    .i_rdata   (i_rdata),
    .i_resp    (i_resp),
    .d_read    (d_read),
    .d_write   (d_write),
    .d_address (d_address),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_resp    (d_resp),
    .read      (read),
    .write     (write),
    .address   (address),
    .wdata     (wdata),
    .resp      (resp),
    .rdata     (rdata)
  );

  always #5 clk = ~clk;

  task automatic nxt();
    @(negedge clk);
  endtask

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] v;
    for (int k = 0; k < LINE_W / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic apply_reset();
    nxt();
    rst = 1'b1;
    i_read = 1'b0; i_address = '0;
    d_read = 1'b0; d_write = 1'b0; d_address = '0; d_wdata = '0;
    resp = 1'b0; rdata = '0;
    nxt();
    nxt();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    n_cmp++;
    if ({read, write, i_resp, d_resp} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_strobes: got %b want 0000", {read, write, i_resp, d_resp});
    end
    n_cmp++;
    if (address !== '0 || wdata !== '0) begin
      n_fail++; $display("FAIL reset_addr_data: got %h / %h want 0 / 0", address, wdata);
    end
    // reset in the middle of a writeback
    nxt(); d_write = 1'b1; d_address = 32'h2000; d_wdata = rand_line(); #1;
    nxt(); #1;
    n_cmp++;
    if (write !== 1'b1) begin n_fail++; $display("FAIL rst_mid_setup: write got %b want 1", write); end
    nxt(); rst = 1'b1; #1;
    nxt(); #1;
    n_cmp++;
    if ({read, write} !== 2'b00) begin
      n_fail++; $display("FAIL rst_mid_strobes: got %b want 00", {read, write});
    end
    nxt(); rst = 1'b0; d_write = 1'b0; resp = 1'b1; #1;
    n_cmp++;
    if ({i_resp, d_resp} !== 2'b00) begin
      n_fail++; $display("FAIL rst_mid_resp: got %b want 00", {i_resp, d_resp});
    end
    nxt(); resp = 1'b0; #1;
    n_cmp++;
    if ({read, write} !== 2'b00) begin
      n_fail++; $display("FAIL rst_mid_idle: got %b want 00", {read, write});
    end
  endtask

  task automatic test_lone_i();
    int d_pulses = 0;
    logic [LINE_W-1:0] a5 = {32{8'hA5}};
    nxt(); i_read = 1'b1; i_address = 32'h60; #1;
    n_cmp++;
    if (read !== 1'b0) begin n_fail++; $display("FAIL lone_i_early: read got %b want 0", read); end
    for (int k = 0; k < 5; k++) begin
      nxt();
      resp  = (k == 3);
      rdata = (k == 3) ? a5 : '0;
      if (k == 4) i_read = 1'b0;
      #1;
      if (d_resp) d_pulses++;
      if (k <= 3) begin
        n_cmp++;
        if (read !== 1'b1 || write !== 1'b0 || address !== 32'h60) begin
          n_fail++;
          $display("FAIL lone_i_strobe[%0d]: got r%b w%b a%h want r1 w0 a60", k, read, write,
                   address);
        end
      end
      if (k == 3) begin
        n_cmp++;
        if (i_resp !== 1'b1 || i_rdata !== a5) begin
          n_fail++; $display("FAIL lone_i_resp: got %b %h want 1 %h", i_resp, i_rdata, a5);
        end
      end
      if (k == 4) begin
        n_cmp++;
        if (read !== 1'b0 || i_resp !== 1'b0) begin
          n_fail++; $display("FAIL lone_i_after: got r%b resp%b want 0 0", read, i_resp);
        end
      end
    end
    resp = 1'b0;
    n_cmp++;
    if (d_pulses != 0) begin n_fail++; $display("FAIL lone_i_dresp: got %0d want 0", d_pulses); end
  endtask

  task automatic test_lone_d();
    int pulses = 0;
    nxt(); d_write = 1'b1; d_address = 32'h1000; d_wdata = 256'h1234; #1;
    for (int k = 0; k < 6; k++) begin
      nxt();
      resp = (k == 4);
      if (k == 5) d_write = 1'b0;
      #1;
      if (d_resp) pulses++;
      if (k <= 4) begin
        n_cmp++;
        if (write !== 1'b1 || read !== 1'b0 || address !== 32'h1000 || wdata !== 256'h1234) begin
          n_fail++;
          $display("FAIL lone_d_hold[%0d]: got w%b r%b a%h d%h want w1 r0 a1000 d1234", k, write,
                   read, address, wdata);
        end
      end else begin
        n_cmp++;
        if (write !== 1'b0) begin n_fail++; $display("FAIL lone_d_end: write got %b want 0", write); end
      end
    end
    resp = 1'b0;
    n_cmp++;
    if (pulses != 1) begin n_fail++; $display("FAIL lone_d_pulses: got %0d want 1", pulses); end
  endtask

  task automatic test_tie();
    apply_reset();
    i_read = 1'b1; i_address = 32'h40; d_read = 1'b1; d_address = 32'h80;
    nxt(); #1;
    n_cmp++;
    if (read !== 1'b1 || address !== 32'h40) begin
      n_fail++; $display("FAIL tie1_first: got r%b a%h want r1 a40", read, address);
    end
    nxt(); resp = 1'b1; #1;
    n_cmp++;
    if (i_resp !== 1'b1 || d_resp !== 1'b0) begin
      n_fail++; $display("FAIL tie1_iresp: got i%b d%b want i1 d0", i_resp, d_resp);
    end
    nxt(); resp = 1'b0; i_read = 1'b0; #1;
    n_cmp++;
    if (read !== 1'b0) begin n_fail++; $display("FAIL tie1_gap: read got %b want 0", read); end
    nxt(); #1;
    n_cmp++;
    if (read !== 1'b1 || address !== 32'h80) begin
      n_fail++; $display("FAIL tie1_second: got r%b a%h want r1 a80", read, address);
    end
    nxt(); resp = 1'b1; #1;
    n_cmp++;
    if (d_resp !== 1'b1 || i_resp !== 1'b0) begin
      n_fail++; $display("FAIL tie1_dresp: got i%b d%b want i0 d1", i_resp, d_resp);
    end
    nxt(); resp = 1'b0; d_read = 1'b0;
    // second tie: previous tie went to I, so D wins now
    nxt(); i_read = 1'b1; d_read = 1'b1;
    nxt(); #1;
    n_cmp++;
    if (read !== 1'b1 || address !== 32'h80) begin
      n_fail++; $display("FAIL tie2_first: got r%b a%h want r1 a80", read, address);
    end
    nxt(); resp = 1'b1; #1;
    n_cmp++;
    if (d_resp !== 1'b1) begin n_fail++; $display("FAIL tie2_dresp: got %b want 1", d_resp); end
    nxt(); resp = 1'b0; d_read = 1'b0;
    nxt(); #1;
    n_cmp++;
    if (read !== 1'b1 || address !== 32'h40) begin
      n_fail++; $display("FAIL tie2_second: got r%b a%h want r1 a40", read, address);
    end
    nxt(); resp = 1'b1; #1;
    nxt(); resp = 1'b0; i_read = 1'b0;
  endtask

  task automatic test_churn();
    logic [LINE_W-1:0] line = rand_line();
    nxt(); d_write = 1'b1; d_address = 32'h3000; d_wdata = line;
    for (int k = 0; k < 4; k++) begin
      nxt();
      d_address = $urandom;
      d_wdata   = rand_line();
      #1;
      n_cmp++;
      if (address !== 32'h3000 || wdata !== line) begin
        n_fail++;
        $display("FAIL churn_hold[%0d]: got a%h d%h want a3000 d%h", k, address, wdata, line);
      end
    end
    nxt(); resp = 1'b1; #1;
    nxt(); resp = 1'b0; d_write = 1'b0;
  endtask

  task automatic test_conflict();
    nxt(); d_read = 1'b1; d_write = 1'b1; d_address = 32'h500;
    nxt(); #1;
    n_cmp++;
    if (write !== 1'b1 || read !== 1'b0) begin
      n_fail++; $display("FAIL conflict_strobe: got r%b w%b want r0 w1", read, write);
    end
    nxt(); resp = 1'b1; #1;
    nxt(); resp = 1'b0; d_read = 1'b0; d_write = 1'b0;
    nxt(); resp = 1'b1; #1;
    n_cmp++;
    if ({i_resp, d_resp} !== 2'b00) begin
      n_fail++; $display("FAIL stray_resp: got %b want 00", {i_resp, d_resp});
    end
    nxt(); resp = 1'b0; #1;
    n_cmp++;
    if ({read, write} !== 2'b00) begin
      n_fail++; $display("FAIL stray_idle: got %b want 00", {read, write});
    end
  endtask

  task automatic test_random();
    int                cur = 0;  // 0: none, 1: I served, 2: D served
    bit                tie_last_d = 1'b1;
    logic              e_rd = 1'b0, e_wr = 1'b0;
    logic [ADDR_W-1:0] e_addr = '0;
    logic [LINE_W-1:0] e_wdata = '0;
    bit                i_act = 0, d_act = 0, i_done = 0, d_done = 0, mem_pend = 0;
    int                mem_lat = 0, op;
    bit                pick_i;
    apply_reset();
    for (int c = 0; c < 3000; c++) begin
      nxt();
      if (i_done) begin
        i_read = 1'b0; i_act = 0; i_done = 0;
      end else if (!i_act && $urandom_range(3) == 0) begin
        i_act = 1; i_read = 1'b1; i_address = $urandom & 32'hFFFF_FFE0;
      end
      if (d_done) begin
        d_read = 1'b0; d_write = 1'b0; d_act = 0; d_done = 0;
      end else if (!d_act && $urandom_range(3) == 0) begin
        d_act = 1; op = $urandom_range(2);
        d_read = (op != 1); d_write = (op != 0);
        d_address = $urandom & 32'hFFFF_FFE0; d_wdata = rand_line();
      end else if (cur == 2 && $urandom_range(1) == 1) begin
        d_address = $urandom; d_wdata = rand_line();
      end
      resp = 1'b0;
      rdata = rand_line();
      if (mem_pend) begin
        if (mem_lat == 0) begin resp = 1'b1; mem_pend = 0; end
        else mem_lat--;
      end else if (cur == 0 && $urandom_range(7) == 0) begin
        resp = 1'b1;
      end
      #1;
      n_cmp++;
      if ({read, write} !== {e_rd, e_wr}) begin
        n_fail++; $display("FAIL rnd_strobe[%0d]: got %b want %b", c, {read, write}, {e_rd, e_wr});
      end
      if (cur != 0) begin
        n_cmp++;
        if (address !== e_addr) begin
          n_fail++; $display("FAIL rnd_addr[%0d]: got %h want %h", c, address, e_addr);
        end
      end
      if (cur == 2 && e_wr) begin
        n_cmp++;
        if (wdata !== e_wdata) begin
          n_fail++; $display("FAIL rnd_wdata[%0d]: got %h want %h", c, wdata, e_wdata);
        end
      end
      n_cmp++;
      if ({i_resp, d_resp} !== {(cur == 1) && resp, (cur == 2) && resp}) begin
        n_fail++;
        $display("FAIL rnd_resp[%0d]: got %b want %b", c, {i_resp, d_resp},
                 {(cur == 1) && resp, (cur == 2) && resp});
      end
      if (resp && cur == 1) begin
        n_cmp++;
        if (i_rdata !== rdata) begin n_fail++; $display("FAIL rnd_irdata[%0d]: got %h want %h", c, i_rdata, rdata); end
      end
      if (resp && cur == 2) begin
        n_cmp++;
        if (d_rdata !== rdata) begin n_fail++; $display("FAIL rnd_drdata[%0d]: got %h want %h", c, d_rdata, rdata); end
      end
      if ((e_rd || e_wr) && !mem_pend && !resp) begin
        mem_pend = 1; mem_lat = $urandom_range(3);
      end
      // transaction-level model of the next grant
      if (cur == 0) begin
        if (i_read && (d_read || d_write)) begin
          pick_i = tie_last_d;
          tie_last_d = !pick_i;
        end else begin
          pick_i = i_read;
        end
        if (pick_i) begin
          cur = 1; e_rd = 1'b1; e_wr = 1'b0; e_addr = i_address;
        end else if (d_read || d_write) begin
          cur = 2; e_rd = d_read && !d_write; e_wr = d_write; e_addr = d_address; e_wdata = d_wdata;
        end
      end else if (resp) begin
        if (cur == 1) i_done = 1; else d_done = 1;
        cur = 0; e_rd = 1'b0; e_wr = 1'b0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_lone_i();
    test_lone_d();
    test_tie();
    test_churn();
    test_conflict();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_arbiter.md
Name: cache_arbiter

Overview:
- Shares the single 256-bit physical memory port between the instruction-cache miss path and the data-cache miss/writeback path of the pipelined RV32I core.
- Sits between the two caches and the physical memory: one requester is served at a time, ties are broken round-robin, and each request is held on the memory side until the memory responds.
- All memory-side outputs are registered.

Parameters:
- ADDR_W, 32, byte address width on all ports.
- LINE_W, 256, cache line width in bits.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- i_read  in  1  instruction-cache line read request; held until i_resp.
- i_address  in  ADDR_W  instruction-cache line address.
- i_rdata  out  LINE_W  line data returned to the instruction cache.
- i_resp  out  1  one-cycle completion pulse to the instruction cache.
- d_read  in  1  data-cache line read request; held until d_resp.
- d_write  in  1  data-cache line writeback request; held until d_resp.
- d_address  in  ADDR_W  data-cache line address.
- d_wdata  in  LINE_W  data-cache writeback line.
- d_rdata  out  LINE_W  line data returned to the data cache.
- d_resp  out  1  one-cycle completion pulse to the data cache.
- read  out  1  physical memory read strobe.
- write  out  1  physical memory write strobe.
- address  out  ADDR_W  physical memory address.
- wdata  out  LINE_W  physical memory write line.
- resp  in  1  physical memory completion pulse.
- rdata  in  LINE_W  physical memory read line.

Behaviour:
- Reset:
  - rst sampled high at posedge puts the FSM in IDLE, clears read/write, and sets last_grant=D so the first tie goes to I.
  - address/wdata are zeroed; i_resp/d_resp are 0.
  - Reset mid-transaction abandons it. No resp is forwarded. A memory resp arriving while in IDLE is ignored.
- States: IDLE, SERVE_I, SERVE_D.
- IDLE:
  - Only i pending (i_read): latch i_address, go to SERVE_I, assert read next cycle.
  - Only d pending (d_read|d_write): latch d_address and d_wdata, go to SERVE_D, drive read=d_read&~d_write and write=d_write next cycle.
  - Both pending: grant the requester not equal to last_grant, then update last_grant.
  - Neither pending: stay in IDLE with read=write=0.
- Conflicting data request: d_read and d_write both high is treated as a write. The write wins and d_read is ignored for that grant.
- SERVE_x:
  - read/write/address/wdata hold constant until the cycle resp=1, regardless of requester input changes.
  - In the resp cycle, x_resp=1 combinationally and x_rdata=rdata. The other requester's resp stays 0.
  - At the next posedge, read=write=0 and the FSM returns to IDLE.
- Requester contract: requesters deassert in the cycle after their resp. IDLE re-arbitrates with fresh requests only.
- Latency:
  - Request seen in IDLE at cycle N: memory strobe at N+1.
  - Memory resp at cycle M: requester resp at cycle M (combinational).
  - Minimum gap between consecutive grants is one IDLE cycle.
- Unused outputs: i_rdata/d_rdata are don't-care when the matching resp=0. Implement them as rdata passthrough.
- Starvation: a requester that stays asserted is granted within one other transaction.

Test Plan:
- Reset: assert rst for 2 cycles mid-SERVE_D -> read=write=0 the cycle after the reset edge, d_resp never pulses, and the FSM is in IDLE.
- Lone I miss:
  - Stimulus: i_read=1, i_address=0x00000060; memory responds 3 cycles after the strobe with rdata=256'hA5..A5.
  - Response: read=1 and address=0x60 one cycle after the request; i_resp=1 with i_rdata=A5..A5 in the resp cycle; read=0 the next cycle; d_resp=0 throughout.
- Lone D writeback: d_write=1, d_address=0x00001000, d_wdata=256'h1234 -> write=1, read=0, address=0x1000, wdata=0x1234 held stable until resp, and d_resp pulses exactly once.
- Simultaneous requests after reset:
  - Stimulus: i_read and d_read asserted together with addresses 0x40 and 0x80.
  - Response: I is served first (address=0x40). After I deasserts, D is served (address=0x80) following a single IDLE cycle.
  - Repeat the tie: D-then-I order holds because last_grant now equals I, so the next tie goes to D.
- Input churn: change d_address/d_wdata while SERVE_D awaits resp -> the memory-side address/wdata keep their latched values.
- Conflict and stray resp:
  - d_read=d_write=1 -> only write=1 is driven.
  - A resp pulse injected in IDLE -> no i_resp or d_resp.
